mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv8_pkg.sv | 18 +
 rtl/dmem_handshake.sv | 63 ++++++
 rtl/mem_stage.sv | 94 +++++++++
 tb/tb_mem_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv8_pkg.sv
// Shared types for the 8-bit RISC pipeline: data/register widths,
// memory-stage FSM states and the EX/MEM pipeline register layout.
package riscv8_pkg;
  localparam int DATA_W = 8;
  localparam int REG_W  = 5;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
  } ex_mem_t;
endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request/ack FSM with a bounded wait; a timeout abandons the
// access and latches a sticky error.
module dmem_handshake
  import riscv8_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ack,
  output mem_state_e state,
  output logic       done,
  output logic       timed_out,
  output logic       mem_error
);
  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e    state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_error <= mem_error | timed_out;
    end
  end

  // cnt holds the number of ACCESS cycles already spent before this one
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: latches the execute result, runs data-memory
// accesses through dmem_handshake, and produces writeback and branch redirect.
module mem_stage
  import riscv8_pkg::*;
#(
  parameter int PC_SIZE = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_SIZE-1:0] PC_jump,
  input  logic              zero,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_write_in,
  input  logic              branch_in,
  input  logic              mem_read_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_write_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pc_src,
  output logic [PC_SIZE-1:0] PC_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_error
);
  ex_mem_t    op;
  mem_state_e state;
  logic       accept, is_mem, alu_only, done, timed_out, load_wb;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = mem_read_in | mem_write_in;
  assign alu_only = accept & ~is_mem;
  // a write wins over a simultaneous read, so only pure loads return memory data
  assign load_wb  = op.mem_read & ~op.mem_write & op.mem_to_reg;

  dmem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & is_mem),
    .ack       (dmem_ack),
    .state     (state),
    .done      (done),
    .timed_out (timed_out),
    .mem_error (mem_error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op           <= '0;
      PC_target    <= '0;
      pc_src       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
    end else begin
      if (accept) begin
        op        <= '{alu_result: ALU_result, store_data: store_data, rd: rd,
                       reg_write: reg_write_in, mem_read: mem_read_in,
                       mem_to_reg: mem_to_reg_in, mem_write: mem_write_in};
        PC_target <= PC_jump;
      end
      pc_src   <= accept & branch_in & zero;
      wb_valid <= alu_only | done | timed_out;
      if (alu_only) begin
        wb_reg_write <= reg_write_in;
        wb_data      <= ALU_result;
      end else if (done) begin
        wb_reg_write <= op.reg_write;
        wb_data      <= load_wb ? dmem_rdata : op.alu_result;
      end else if (timed_out) begin
        wb_reg_write <= 1'b0;
        wb_data      <= op.alu_result;
      end
    end
  end

  assign wb_rd      = op.rd;
  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = dmem_req & op.mem_write;
  assign dmem_addr  = op.alu_result;
  assign dmem_wdata = op.store_data;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, load, store, branch, timeout and
// mid-access reset, checked with immediate assertions against hand values.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] PC_jump;
  logic        zero;
  logic [7:0]  ALU_result, store_data;
  logic [4:0]  rd;
  logic        reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [7:0]  dmem_rdata;
  logic        pc_src;
  logic [31:0] PC_target;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        mem_error;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.PC_SIZE(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .PC_jump(PC_jump), .zero(zero), .ALU_result(ALU_result), .store_data(store_data),
    .rd(rd), .reg_write_in(reg_write_in), .branch_in(branch_in),
    .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc_src(pc_src), .PC_target(PC_target),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; PC_jump = 0; zero = 0; ALU_result = 0; store_data = 0; rd = 0;
    reg_write_in = 0; branch_in = 0; mem_read_in = 0; mem_to_reg_in = 0; mem_write_in = 0;
  endtask

  initial begin
    rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
    idle_inputs();
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_PC_target", PC_target, 32'd0);
    chk("rst_mem_error", 32'(mem_error), 32'd0);
    rst_n = 1;
    tick();

    // ALU op
    in_valid = 1; ALU_result = 8'h3C; rd = 5'd5; reg_write_in = 1;
    chk("alu_in_ready0", 32'(in_ready), 32'd1);
    tick(); idle_inputs();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_data", 32'(wb_data), 32'h3C);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_reg_write", 32'(wb_reg_write), 32'd1);
    chk("alu_in_ready1", 32'(in_ready), 32'd1);
    chk("alu_dmem_req", 32'(dmem_req), 32'd0);
    tick();
    chk("alu_wb_pulse_end", 32'(wb_valid), 32'd0);
    chk("alu_in_ready2", 32'(in_ready), 32'd1);

    // stray ack while idle is ignored
    dmem_ack = 1; dmem_rdata = 8'hFF;
    tick(); dmem_ack = 0;
    chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);

    // load, ack in third ACCESS cycle
    in_valid = 1; ALU_result = 8'h10; rd = 5'd7; reg_write_in = 1;
    mem_read_in = 1; mem_to_reg_in = 1;
    tick(); idle_inputs();
    chk("ld_req_c1", 32'(dmem_req), 32'd1);
    chk("ld_in_ready_c1", 32'(in_ready), 32'd0);
    chk("ld_addr", 32'(dmem_addr), 32'h10);
    chk("ld_we", 32'(dmem_we), 32'd0);
    chk("ld_wb_valid_c1", 32'(wb_valid), 32'd0);
    tick();
    chk("ld_req_c2", 32'(dmem_req), 32'd1);
    tick();
    chk("ld_req_c3", 32'(dmem_req), 32'd1);
    chk("ld_in_ready_c3", 32'(in_ready), 32'd0);
    dmem_ack = 1; dmem_rdata = 8'hA5;
    tick(); dmem_ack = 0; dmem_rdata = 8'h00;
    chk("ld_req_drop", 32'(dmem_req), 32'd0);
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_data", 32'(wb_data), 32'hA5);
    chk("ld_wb_rd", 32'(wb_rd), 32'd7);
    chk("ld_wb_reg_write", 32'(wb_reg_write), 32'd1);
    chk("ld_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("ld_wb_pulse_end", 32'(wb_valid), 32'd0);

    // store, ack on first ACCESS cycle
    in_valid = 1; ALU_result = 8'h20; store_data = 8'h7E; rd = 5'd2; mem_write_in = 1;
    tick(); idle_inputs();
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_addr", 32'(dmem_addr), 32'h20);
    chk("st_wdata", 32'(dmem_wdata), 32'h7E);
    dmem_ack = 1; dmem_rdata = 8'h55;
    tick(); dmem_ack = 0;
    chk("st_we_drop", 32'(dmem_we), 32'd0);
    chk("st_req_drop", 32'(dmem_req), 32'd0);
    chk("st_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("st_wb_data", 32'(wb_data), 32'h20);

    // read and write both set: write wins
    in_valid = 1; ALU_result = 8'h33; store_data = 8'h44; rd = 5'd9; reg_write_in = 1;
    mem_read_in = 1; mem_write_in = 1; mem_to_reg_in = 1;
    tick(); idle_inputs();
    chk("rw_we", 32'(dmem_we), 32'd1);
    dmem_ack = 1; dmem_rdata = 8'h99;
    tick(); dmem_ack = 0;
    chk("rw_wb_valid", 32'(wb_valid), 32'd1);
    chk("rw_wb_data", 32'(wb_data), 32'h33);

    // taken branch
    in_valid = 1; branch_in = 1; zero = 1; PC_jump = 32'h104;
    tick(); idle_inputs();
    chk("br_pc_src", 32'(pc_src), 32'd1);
    chk("br_PC_target", PC_target, 32'h104);
    tick();
    chk("br_pc_src_end", 32'(pc_src), 32'd0);
    chk("br_PC_target_hold", PC_target, 32'h104);
    // not taken
    in_valid = 1; branch_in = 1; zero = 0; PC_jump = 32'h200;
    tick(); idle_inputs();
    chk("bnt_pc_src", 32'(pc_src), 32'd0);
    chk("bnt_PC_target", PC_target, 32'h200);

    // load never acked: 16 ACCESS cycles then timeout
    in_valid = 1; ALU_result = 8'h40; rd = 5'd3; reg_write_in = 1;
    mem_read_in = 1; mem_to_reg_in = 1;
    tick(); idle_inputs();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_req_c%0d", i + 1), 32'(dmem_req), 32'd1);
      if (i == 1) begin
        in_valid = 1; ALU_result = 8'hEE; rd = 5'd1; reg_write_in = 1;
      end
      if (i == 2) begin
        idle_inputs();
        chk("to_busy_no_wb", 32'(wb_valid), 32'd0);
        chk("to_busy_addr", 32'(dmem_addr), 32'h40);
      end
      tick();
    end
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_mem_error", 32'(mem_error), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("to_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1; ALU_result = 8'h11; rd = 5'd4; reg_write_in = 1;
    tick(); idle_inputs();
    chk("to_err_sticky", 32'(mem_error), 32'd1);
    chk("to_next_wb_data", 32'(wb_data), 32'h11);

    // reset in the middle of an access
    in_valid = 1; ALU_result = 8'h50; rd = 5'd6; reg_write_in = 1; mem_read_in = 1;
    tick(); idle_inputs();
    tick();
    chk("rm_req_before", 32'(dmem_req), 32'd1);
    rst_n = 0;
    #1;
    chk("rm_req_async", 32'(dmem_req), 32'd0);
    chk("rm_mem_error_clr", 32'(mem_error), 32'd0);
    tick();
    rst_n = 1;
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    dmem_ack = 1; dmem_rdata = 8'h77;
    tick(); dmem_ack = 0;
    chk("rm_no_wb_valid", 32'(wb_valid), 32'd0);
    chk("rm_in_ready_after", 32'(in_ready), 32'd1);
    tick();
    chk("rm_no_wb_valid2", 32'(wb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
